// File: rtl/sop_eval_pkg.sv
// rtl/sop_eval_pkg.sv - shared state encoding and width helpers for the SOP error evaluator
package sop_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of the error sum: (2^n_out-1)*2^n_in always fits in n_out+n_in bits.
    function automatic int sum_width(input int n_in, input int n_out);
        return n_in + n_out;
    endfunction

    // Width of the over-threshold counter: must hold the full count 2^n_in.
    function automatic int cnt_width(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/sop_abs_diff.sv
// rtl/sop_abs_diff.sv - combinational absolute difference of two unsigned words
module sop_abs_diff #(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    // Subtract the smaller from the larger so the result never underflows.
    always_comb begin
        y = '0;
        if (a >= b) begin
            y = a - b;
        end else begin
            y = b - a;
        end
    end

endmodule

// File: rtl/sop_error_evaluator.sv
// rtl/sop_error_evaluator.sv - exhaustive sweep comparing exact and approximate SOP circuits
module sop_error_evaluator
    import sop_eval_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int ET    = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    output logic [N_IN-1:0]                     vec,
    input  logic [N_OUT-1:0]                    exact_out,
    input  logic [N_OUT-1:0]                    approx_out,
    output logic                                busy,
    output logic                                done,
    output logic [N_OUT-1:0]                    max_err,
    output logic [sum_width(N_IN, N_OUT)-1:0]   sum_err,
    output logic [cnt_width(N_IN)-1:0]          over_cnt,
    output logic                                pass
);

    localparam int              SUM_W    = sum_width(N_IN, N_OUT);
    localparam int              CNT_W    = cnt_width(N_IN);
    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam logic [31:0]     ET_W     = 32'(ET);

    state_t           state_q;
    state_t           state_d;
    logic             armed_q;
    logic             valid_q;
    logic [N_OUT-1:0] diff_c;
    logic [N_OUT-1:0] diff_q;

    sop_abs_diff #(
        .W (N_OUT)
    ) u_abs_diff (
        .a (exact_out),
        .b (approx_out),
        .y (diff_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status decode; start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                busy = 1'b1;
                if (armed_q && (vec == VEC_LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stimulus counter, stage-1 difference register and stage-2 accumulators.
    // The first SWEEP cycle only arms the pipeline so vec=0 gets a full
    // settling cycle like every later vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec      <= '0;
            armed_q  <= 1'b0;
            valid_q  <= 1'b0;
            diff_q   <= '0;
            max_err  <= '0;
            sum_err  <= '0;
            over_cnt <= '0;
        end else begin
            if (valid_q) begin
                if (diff_q > max_err) begin
                    max_err <= diff_q;
                end
                sum_err <= sum_err + SUM_W'(diff_q);
                if (32'(diff_q) > ET_W) begin
                    over_cnt <= over_cnt + CNT_W'(1);
                end
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vec      <= '0;
                        armed_q  <= 1'b0;
                        valid_q  <= 1'b0;
                        diff_q   <= '0;
                        max_err  <= '0;
                        sum_err  <= '0;
                        over_cnt <= '0;
                    end
                end
                SWEEP: begin
                    if (!armed_q) begin
                        armed_q <= 1'b1;
                    end else begin
                        diff_q  <= diff_c;
                        valid_q <= 1'b1;
                        if (vec != VEC_LAST) begin
                            vec <= vec + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    valid_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Verdict follows the worst-case error directly.
    always_comb begin
        pass = (32'(max_err) <= ET_W);
    end

endmodule

// File: doc/sop_error_evaluator.md
# sop_error_evaluator

Sequential exhaustive error evaluator for generated approximate SOP circuits. It drives every input vector to an exact circuit and an approximate circuit in parallel and reads both responses back. It computes the per-vector absolute error, and accumulates the worst-case error, the total error and the count of vectors over threshold. It sits in the verification/characterisation harness beside each synthesized approximate netlist, on the consuming side of that netlist's input/output interface.

## Interface
- N_IN, 4, number of primary inputs swept (2^N_IN vectors)
- N_OUT, 3, output width of both circuits, unsigned weighted (bit 0 = LSB)
- ET, 3, error threshold; pass iff worst-case error <= ET
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- vec  out  N_IN  stimulus driven to both circuits' in0..in(N_IN-1)
- exact_out  in  N_OUT  exact circuit response to vec (combinational)
- approx_out  in  N_OUT  approximate circuit response to vec (combinational)
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse, results final
- max_err  out  N_OUT  worst-case absolute error
- sum_err  out  N_OUT+N_IN  sum of absolute errors over all vectors
- over_cnt  out  N_IN+1  number of vectors with error > ET
- pass  out  1  max_err <= ET, valid with done and held after

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE, start=1: clear accumulators, vec<=0, go to SWEEP. busy=1.
- SWEEP, each cycle:
  - Stage 1 registers diff_q = |exact_out - approx_out| (N_OUT bits; no overflow possible) with valid_q=1.
  - vec increments.
  - When vec = 2^N_IN-1 is sampled, vec holds and the FSM goes to DRAIN.
- Stage 2, whenever valid_q=1:
  - max_err <= max(max_err, diff_q)
  - sum_err += diff_q
  - over_cnt += (diff_q > ET)
- DRAIN: valid_q clears after the final accumulation. The FSM goes to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. pass is computed combinationally from max_err.
- Results hold from DONE until the next start is accepted.
- start while busy or in DONE: ignored.
- Reset, including mid-sweep: state IDLE. All outputs and accumulators 0 except pass=1 (max_err=0 <= ET). vec=0, valid_q=0.
- Accumulator widths are sized so full-range sweeps never wrap. sum_err worst case is (2^N_OUT-1)*2^N_IN.

## Timing
- start sampled at edge E. vec=k is stable throughout cycle E+1+k, for k = 0..2^N_IN-1.
- Responses are sampled one edge after vec changes. The external circuits get one full cycle of combinational settling.
- Last diff is registered at E+2^N_IN+1. Last accumulation occurs at E+2^N_IN+2.
- done is high for exactly the cycle following edge E+2^N_IN+2. With N_IN=4: total 19 cycles from start to done.
- busy rises the cycle after E and falls in the DONE cycle.
- vec does not wrap. It holds at 2^N_IN-1 through DRAIN/DONE and returns to 0 only on the next start.

## Structure
- Package sop_eval_pkg holds:
  - state enum (IDLE, SWEEP, DRAIN, DONE)
  - width constants/functions for sum_err and over_cnt derived from N_IN, N_OUT
- Sub-module sop_abs_diff (combinational |a-b| for N_OUT-bit unsigned) feeds stage 1.
- Everything else lives in a single module.

## Test plan
- Identity: approx_out = exact_out = 2-bit adder {in1,in0}+{in3,in2}. Required: max_err=0, sum_err=0, over_cnt=0, pass=1, done exactly 19 cycles after start.
- Constant approximation: approx_out=3 against the same exact adder, ET=3. Required: max_err=3, sum_err=20, over_cnt=0, pass=1.
- Same stimulus with ET=2. Required: max_err=3, sum_err=20, over_cnt=2, pass=0.
- start pulsed repeatedly during SWEEP and in the DONE cycle. Required: no restart, single done, results unchanged.
- rst_n low at cycle 8 of a sweep. Required: outputs zero immediately (pass=1), busy=0, IDLE. A new start then gives a full correct 19-cycle sweep.
- Back-to-back sweeps: start asserted in the cycle after done. Required: accumulators cleared and second results independent of the first.
